// File: rtl/csel_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-select adder/subtractor.
package csel_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int calc_nblk(input int width, input int blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/csel_blk.sv
// Combinational dual-carry block adder: sums the block for carry-in 0 and carry-in 1 in parallel.
module csel_blk #(
  parameter int BLK = 16
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic           c0,
  output logic [BLK-1:0] sum1,
  output logic           c1
);

  assign {c0, sum0} = {1'b0, a} + {1'b0, b};
  assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

endmodule

// File: rtl/csel_add_pipe.sv
// Two-stage carry-select add/sub: stage 1 precomputes per-block speculative sums,
// stage 2 walks the block carry-select chain. Valid/ready handshake with backpressure.
module csel_add_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = calc_nblk(WIDTH, BLK);

  if (WIDTH < 2 || BLK < 1 || (WIDTH % BLK) != 0) begin : g_param_err
    $error("csel_add_pipe: WIDTH must be >= 2 and an exact multiple of BLK");
  end

  typedef struct packed {
    logic [BLK-1:0] sum0;
    logic           c0;
    logic [BLK-1:0] sum1;
    logic           c1;
  } s1_blk_t;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  s1_blk_t          s1_d [NBLK];
  s1_blk_t          s1_q [NBLK];
  logic             s1_valid, s2_valid;
  logic             s1_ready, s2_ready;
  logic             s1_amsb, s1_bmsb;
  logic [WIDTH-1:0] sum_nx;
  logic [NBLK:0]    c;

  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_eff = (op == OP_SUB) ? ~cin : cin;

  // Block 0 resolves its real carry now; mirroring it into both halves lets
  // stage 2 run one uniform select chain seeded with c[0] = 0.
  logic [BLK-1:0] blk0_sum;
  logic           blk0_c;
  assign {blk0_c, blk0_sum} = {1'b0, a[BLK-1:0]} + {1'b0, b_eff[BLK-1:0]} + {{BLK{1'b0}}, c_eff};
  assign s1_d[0] = '{sum0: blk0_sum, c0: blk0_c, sum1: blk0_sum, c1: blk0_c};

  for (genvar k = 1; k < NBLK; k++) begin : g_blk
    logic [BLK-1:0] s0, s1;
    logic           c0, c1;
    csel_blk #(.BLK(BLK)) u_blk (
      .a    (a[k*BLK +: BLK]),
      .b    (b_eff[k*BLK +: BLK]),
      .sum0 (s0),
      .c0   (c0),
      .sum1 (s1),
      .c1   (c1)
    );
    assign s1_d[k] = '{sum0: s0, c0: c0, sum1: s1, c1: c1};
  end

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
      for (int k = 0; k < NBLK; k++) s1_q[k] <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q    <= s1_d;
        s1_amsb <= a[WIDTH-1];
        s1_bmsb <= b_eff[WIDTH-1];
      end
    end
  end

  always_comb begin
    c      = '0;
    sum_nx = '0;
    for (int k = 0; k < NBLK; k++) begin
      sum_nx[k*BLK +: BLK] = c[k] ? s1_q[k].sum1 : s1_q[k].sum0;
      c[k+1]               = c[k] ? s1_q[k].c1   : s1_q[k].c0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_nx;
        cout <= c[NBLK];
        ovf  <= (s1_amsb == s1_bmsb) && (sum_nx[WIDTH-1] != s1_amsb);
      end
    end
  end

endmodule

// File: tb/tb_csel_add_pipe.sv
// Self-checking bench for csel_add_pipe: directed cases, backpressure, reset, and
// randomized streams on 32/16, 8/4 and 12/12 instances against an arithmetic model.
module tb_csel_add_pipe;
  import csel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0, cout, ovf;
  logic [31:0] a = '0, b = '0, sum;
  op_e         op = OP_ADD;

  logic        in_valid_8 = 1'b0, in_ready_8, cin_8 = 1'b0, out_valid_8, out_ready_8 = 1'b0, cout_8, ovf_8;
  logic [7:0]  a_8 = '0, b_8 = '0, sum_8;
  op_e         op_8 = OP_ADD;

  logic        in_valid_12 = 1'b0, in_ready_12, cin_12 = 1'b0, out_valid_12, out_ready_12 = 1'b0, cout_12, ovf_12;
  logic [11:0] a_12 = '0, b_12 = '0, sum_12;
  op_e         op_12 = OP_ADD;

  csel_add_pipe #(.WIDTH(32), .BLK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  csel_add_pipe #(.WIDTH(8), .BLK(4)) dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .a(a_8), .b(b_8),
    .cin(cin_8), .op(op_8), .out_valid(out_valid_8), .out_ready(out_ready_8), .sum(sum_8),
    .cout(cout_8), .ovf(ovf_8));

  csel_add_pipe #(.WIDTH(12), .BLK(12)) dut_12 (
    .clk(clk), .rst(rst), .in_valid(in_valid_12), .in_ready(in_ready_12), .a(a_12), .b(b_12),
    .cin(cin_12), .op(op_12), .out_valid(out_valid_12), .out_ready(out_ready_12), .sum(sum_12),
    .cout(cout_12), .ovf(ovf_12));

  typedef struct {
    logic [31:0] s;
    bit          co;
    bit          ov;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q32[$], q8[$], q12[$];

  // Plain integer arithmetic: unsigned for sum/carry, signed range test for overflow.
  function automatic exp_t model(input int w, input logic [31:0] ta, input logic [31:0] tb_,
                                 input bit sub, input bit ci);
    exp_t   m;
    longint one, mask, ua, ub, sa, sb, r, rs;
    one  = 1;
    mask = (one << w) - 1;
    ua   = longint'(ta) & mask;
    ub   = longint'(tb_) & mask;
    sa   = (ua >= (one << (w-1))) ? ua - (one << w) : ua;
    sb   = (ub >= (one << (w-1))) ? ub - (one << w) : ub;
    if (!sub) begin
      r    = ua + ub + longint'(ci);
      m.co = ((r >> w) & 1) != 0;
      rs   = sa + sb + longint'(ci);
    end else begin
      r    = ua - ub - longint'(ci);
      m.co = (ua >= ub + longint'(ci));
      rs   = sa - sb - longint'(ci);
    end
    m.s  = 32'(r & mask);
    m.ov = (rs >= (one << (w-1))) || (rs < -(one << (w-1)));
    return m;
  endfunction

  // Drives one beat into an empty 32-bit pipe; lat counts cycles from accept to out_valid.
  task automatic run_beat(input logic [31:0] ta, input logic [31:0] tb_, input bit sub, input bit ci,
                          output logic [31:0] rs, output bit rco, output bit rov, output int lat);
    bit acc;
    rs = '0; rco = 1'b0; rov = 1'b0; lat = -1;
    @(negedge clk);
    a = ta; b = tb_; op = sub ? OP_SUB : OP_ADD; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    #1 acc = in_ready;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) in_valid = 1'b0;
      if (acc && out_valid && lat < 0) begin
        lat = i; rs = sum; rco = cout; rov = ovf;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum got=%h want=0", sum); end
    if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", cout); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [5], tbv [5], es [5], rs;
    bit          sb [5], ec [5], eo [5], rco, rov;
    int          lat;
    exp_t        m;
    ta  = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000};
    tbv = '{32'h1, 32'h1, 32'h1, 32'd7, 32'h1};
    sb  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es  = '{32'h00010000, 32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
    ec  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    eo  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_beat(ta[i], tbv[i], sb[i], 1'b0, rs, rco, rov, lat);
      n_checks += 4;
      if (lat !== 2) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=2", i, lat); end
      if (rs !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got=%h want=%h", i, rs, es[i]); end
      if (rco !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout got=%b want=%b", i, rco, ec[i]); end
      if (rov !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf got=%b want=%b", i, rov, eo[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      bit          rsub, rci;
      ra = $urandom; rb = $urandom; rsub = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
      m = model(32, ra, rb, rsub, rci);
      run_beat(ra, rb, rsub, rci, rs, rco, rov, lat);
      n_checks += 2;
      if (lat !== 2) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d want=2", i, lat); end
      if ({rs, rco, rov} !== {m.s, m.co, m.ov}) begin
        n_fail++;
        $display("FAIL rnd%0d_result got=%h/%b/%b want=%h/%b/%b", i, rs, rco, rov, m.s, m.co, m.ov);
      end
    end
  endtask

  // Shared per-cycle checks of the 32-bit stream tests live inline in each task below.
  task automatic test_backpressure();
    logic [31:0] ba [4], bb [4], prev_sum;
    int          sent, got;
    bit          prev_stall;
    exp_t        e;
    ba = '{32'h0000FFFF, 32'h12345678, 32'hFFFFFFFF, 32'h80000000};
    bb = '{32'h00000001, 32'h11111111, 32'h00000001, 32'h00000001};
    sent = 0; got = 0; prev_stall = 1'b0; prev_sum = '0; q32.delete();
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      if (sent < 4) begin a = ba[sent]; b = bb[sent]; op = OP_ADD; cin = 1'b0; end
      #1;
      n_checks++;
      if (in_ready !== ((q32.size() < 2) || out_ready)) begin
        n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b occ=%0d", cyc, in_ready, q32.size());
      end
      if (cyc == 2) begin
        n_checks += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
        if (sent !== 2) begin n_fail++; $display("FAIL bp_accepted_before_full got=%0d want=2", sent); end
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== prev_sum) begin
          n_fail++; $display("FAIL bp_hold got=%b/%h want=1/%h", out_valid, sum, prev_sum);
        end
      end
      if (in_valid && in_ready) begin q32.push_back(model(32, a, b, 1'b0, 1'b0)); sent++; end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious_out got=%h want=none", sum);
        end else begin
          e = q32.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
            n_fail++; $display("FAIL bp_beat%0d got=%h/%b/%b want=%h/%b/%b", got, sum, cout, ovf, e.s, e.co, e.ov);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (got !== 4) begin n_fail++; $display("FAIL bp_delivered got=%0d want=4", got); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rs;
    bit          rco, rov;
    int          lat;
    @(negedge clk);
    a = 32'h1; b = 32'h2; op = OP_ADD; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 32'h3;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_out_valid got=%b want=1", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_in_ready got=%b want=0", in_ready); end
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_in_ready got=%b want=1", in_ready); end
    if (sum !== 32'h0) begin n_fail++; $display("FAIL rst_async_sum got=%h want=0", sum); end
    @(negedge clk);
    rst = 1'b0;
    run_beat(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b1, rs, rco, rov, lat);
    n_checks += 2;
    if (lat !== 2) begin n_fail++; $display("FAIL rst_post_latency got=%0d want=2", lat); end
    if ({rs, rco, rov} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rst_post_result got=%h/%b/%b want=00000000/1/0", rs, rco, rov);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_sum;
    bit          prev_stall, drain;
    int          full_xfers;
    exp_t        e;
    prev_stall = 1'b0; prev_sum = '0; full_xfers = 0; q32.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drain = (cyc >= 300);
      if (drain && q32.size() == 0) break;
      @(negedge clk);
      in_valid  = !drain && ($urandom_range(0, 7) != 0);
      out_ready = drain || ($urandom_range(0, 1) != 0);
      a = $urandom; b = $urandom; op = op_e'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (in_ready !== ((q32.size() < 2) || out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b occ=%0d", cyc, in_ready, q32.size());
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== prev_sum) begin
          n_fail++; $display("FAIL b2b_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, sum, prev_sum);
        end
      end
      if (q32.size() == 2 && out_valid && out_ready && in_valid) full_xfers++;
      if (in_valid && in_ready) q32.push_back(model(32, a, b, op == OP_SUB, cin));
      if (out_valid && out_ready) begin
        n_checks++;
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious_out cyc=%0d got=%h want=none", cyc, sum);
        end else begin
          e = q32.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
            n_fail++; $display("FAIL b2b_result cyc=%0d got=%h/%b/%b want=%h/%b/%b", cyc, sum, cout, ovf, e.s, e.co, e.ov);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks += 2;
    if (q32.size() !== 0) begin n_fail++; $display("FAIL b2b_undelivered got=%0d want=0", q32.size()); end
    if (full_xfers == 0) begin n_fail++; $display("FAIL b2b_full_overlap got=0 want>0"); end
  endtask

  task automatic test_sweep();
    bit   drain, st8, st12;
    logic [7:0]  ps8;
    logic [11:0] ps12;
    exp_t e;
    st8 = 1'b0; st12 = 1'b0; ps8 = '0; ps12 = '0; q8.delete(); q12.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      drain = (cyc >= 400);
      if (drain && q8.size() == 0 && q12.size() == 0) break;
      @(negedge clk);
      in_valid_8  = !drain && ($urandom_range(0, 3) != 0);
      out_ready_8 = drain || ($urandom_range(0, 3) != 0);
      a_8 = 8'($urandom); b_8 = 8'($urandom); op_8 = op_e'($urandom_range(0, 1)); cin_8 = 1'($urandom_range(0, 1));
      in_valid_12  = !drain && ($urandom_range(0, 3) != 0);
      out_ready_12 = drain || ($urandom_range(0, 2) != 0);
      a_12 = 12'($urandom); b_12 = 12'($urandom); op_12 = op_e'($urandom_range(0, 1)); cin_12 = 1'($urandom_range(0, 1));
      #1;
      n_checks += 2;
      if (in_ready_8 !== ((q8.size() < 2) || out_ready_8)) begin
        n_fail++; $display("FAIL w8_in_ready cyc=%0d got=%b occ=%0d", cyc, in_ready_8, q8.size());
      end
      if (in_ready_12 !== ((q12.size() < 2) || out_ready_12)) begin
        n_fail++; $display("FAIL w12_in_ready cyc=%0d got=%b occ=%0d", cyc, in_ready_12, q12.size());
      end
      if (st8) begin
        n_checks++;
        if (out_valid_8 !== 1'b1 || sum_8 !== ps8) begin
          n_fail++; $display("FAIL w8_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid_8, sum_8, ps8);
        end
      end
      if (st12) begin
        n_checks++;
        if (out_valid_12 !== 1'b1 || sum_12 !== ps12) begin
          n_fail++; $display("FAIL w12_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid_12, sum_12, ps12);
        end
      end
      if (in_valid_8 && in_ready_8) q8.push_back(model(8, 32'(a_8), 32'(b_8), op_8 == OP_SUB, cin_8));
      if (in_valid_12 && in_ready_12) q12.push_back(model(12, 32'(a_12), 32'(b_12), op_12 == OP_SUB, cin_12));
      if (out_valid_8 && out_ready_8) begin
        n_checks++;
        if (q8.size() == 0) begin
          n_fail++; $display("FAIL w8_spurious_out cyc=%0d got=%h want=none", cyc, sum_8);
        end else begin
          e = q8.pop_front();
          if ({sum_8, cout_8, ovf_8} !== {e.s[7:0], e.co, e.ov}) begin
            n_fail++; $display("FAIL w8_result cyc=%0d got=%h/%b/%b want=%h/%b/%b", cyc, sum_8, cout_8, ovf_8, e.s[7:0], e.co, e.ov);
          end
        end
      end
      if (out_valid_12 && out_ready_12) begin
        n_checks++;
        if (q12.size() == 0) begin
          n_fail++; $display("FAIL w12_spurious_out cyc=%0d got=%h want=none", cyc, sum_12);
        end else begin
          e = q12.pop_front();
          if ({sum_12, cout_12, ovf_12} !== {e.s[11:0], e.co, e.ov}) begin
            n_fail++; $display("FAIL w12_result cyc=%0d got=%h/%b/%b want=%h/%b/%b", cyc, sum_12, cout_12, ovf_12, e.s[11:0], e.co, e.ov);
          end
        end
      end
      st8  = out_valid_8 && !out_ready_8;   ps8  = sum_8;
      st12 = out_valid_12 && !out_ready_12; ps12 = sum_12;
    end
    @(negedge clk);
    in_valid_8 = 1'b0; in_valid_12 = 1'b0;
    n_checks += 2;
    if (q8.size() !== 0) begin n_fail++; $display("FAIL w8_undelivered got=%0d want=0", q8.size()); end
    if (q12.size() !== 0) begin n_fail++; $display("FAIL w12_undelivered got=%0d want=0", q12.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
